// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: start / DATA_BITS LSB-first / optional parity / stop, valid-ready output holding register.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 majority vote around each nominal sample point.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int ODD_PARITY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 os_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE + 1);
  localparam int BW = 3;
  localparam logic ODD = (ODD_PARITY != 0);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_nx;
  logic [TW-1:0]         tick_cnt, tick_cnt_nx;
  logic [BW-1:0]         bit_cnt, bit_cnt_nx;
  logic [DATA_BITS-1:0]  shreg, shreg_nx;
  logic                  perr, perr_nx;
  logic                  ferr_q, ferr_nx;
  logic                  done_q, done_nx;
  logic                  rx_meta, rx_s;
  logic                  sample;

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Decision moves one tick late (c+1); restarting the counter at 1 keeps the bit grid unchanged.
  localparam int LAG = 1;
  logic [1:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          hist <= 2'b11;
    else if (os_tick) hist <= {hist[0], rx_s};
  end

  assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  localparam int LAG = 0;
  assign sample = rx_s;
`endif

  localparam logic [TW-1:0] START_PT = TW'(OVERSAMPLE / 2 - 1 + LAG);
  localparam logic [TW-1:0] BIT_PT   = TW'(OVERSAMPLE - 1 + LAG);
  localparam logic [TW-1:0] RESTART  = TW'(LAG);

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WAIT_HIGH;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      tick_cnt <= tick_cnt_nx;
      bit_cnt  <= bit_cnt_nx;
      shreg    <= shreg_nx;
      perr     <= perr_nx;
      ferr_q   <= ferr_nx;
      done_q   <= done_nx;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx    = state;
    tick_cnt_nx = tick_cnt;
    bit_cnt_nx  = bit_cnt;
    shreg_nx    = shreg;
    perr_nx     = perr;
    ferr_nx     = ferr_q;
    done_nx     = 1'b0;
    if (os_tick) begin
      unique case (state)
        WAIT_HIGH: if (rx_s) state_nx = IDLE;
        IDLE: if (!rx_s) begin
          state_nx    = START;
          tick_cnt_nx = '0;
        end
        START: if (tick_cnt == START_PT) begin
          if (!sample) begin
            state_nx    = DATA;
            tick_cnt_nx = RESTART;
            bit_cnt_nx  = '0;
            perr_nx     = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          tick_cnt_nx = tick_cnt + 1'b1;
        end
        DATA: if (tick_cnt == BIT_PT) begin
          shreg_nx[bit_cnt] = sample;
          tick_cnt_nx       = RESTART;
          if (bit_cnt == LAST_BIT) state_nx = (PARITY_EN != 0) ? PARITY : STOP;
          else                     bit_cnt_nx = bit_cnt + 1'b1;
        end else begin
          tick_cnt_nx = tick_cnt + 1'b1;
        end
        PARITY: if (tick_cnt == BIT_PT) begin
          perr_nx     = ((^shreg) ^ sample) != ODD;
          tick_cnt_nx = RESTART;
          state_nx    = STOP;
        end else begin
          tick_cnt_nx = tick_cnt + 1'b1;
        end
        STOP: if (tick_cnt == BIT_PT) begin
          ferr_nx     = !sample;
          done_nx     = 1'b1;
          tick_cnt_nx = '0;
          state_nx    = sample ? IDLE : WAIT_HIGH;
        end else begin
          tick_cnt_nx = tick_cnt + 1'b1;
        end
        default: state_nx = WAIT_HIGH;
      endcase
    end
  end

  // Holding register: a completed frame loads if empty or draining this cycle, otherwise it is dropped.
  // NOTE: the data register is reset too, because the outputs must read 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (done_q) begin
      if (!rx_valid || rx_ready) begin
        rx_data    <= shreg;
        parity_err <= perr;
        frame_err  <= ferr_q;
        rx_valid   <= 1'b1;
        overrun    <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  assign busy = (state != IDLE) && (state != WAIT_HIGH);

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: table vectors, randomized frames against a frame-level model,
// and hand-written sequences for break, glitch, overrun and mid-frame reset.
module tb_uart_rx_os;

  localparam int DB       = 8;
  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLK  = OS * TICK_DIV;
  localparam bit ODD      = 1'b1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          os_tick = 1'b0;
  logic          rx = 1'b1;
  logic          rx_ready = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid, parity_err, frame_err, overrun, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int valid_cycles = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } word_t;

  typedef struct {
    logic [7:0] d;
    logic       pbit;
    logic       stop;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  word_t got_q[$];

  uart_rx_os #(
    .DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_EN(1), .ODD_PARITY(1)
  ) dut (
    .clk(clk), .rst(rst), .os_tick(os_tick), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      os_tick = 1'b1;
      @(negedge clk);
      os_tick = 1'b0;
    end
  end

  // Records every accepted word; sampled mid-cycle, before the transferring edge.
  always @(negedge clk) begin
    if (rx_valid) valid_cycles++;
    if (rx_valid && rx_ready) got_q.push_back({rx_data, parity_err, frame_err, overrun});
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ ODD;
  endfunction

  function automatic word_t mk(input logic [7:0] d, input logic pe, input logic fe, input logic ov);
    word_t w;
    w.data = d; w.perr = pe; w.ferr = fe; w.ovr = ov;
    return w;
  endfunction

  // Frame-level reference: what the consumer should see for a frame put on the wire.
  function automatic word_t model(input logic [7:0] d, input logic pbit, input logic stop);
    return mk(d, ((^d) ^ pbit) != ODD, !stop, 1'b0);
  endfunction

  task automatic hold_bits(input int nbits);
    repeat (nbits * BIT_CLK) @(negedge clk);
  endtask

  // Drives one frame; leaves rx at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    hold_bits(1);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      hold_bits(1);
    end
    rx = pbit;
    hold_bits(1);
    rx = stop;
    hold_bits(1);
  endtask

  task automatic expect_word(input string name, input word_t exp);
    int n;
    n = 0;
    while (got_q.size() == 0 && n < 2 * BIT_CLK) begin
      @(negedge clk);
      n++;
    end
    if (got_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no word within %0d clk, expected data %0h", name, 2 * BIT_CLK, exp.data);
    end else begin
      word_t w;
      w = got_q.pop_front();
      check({name, ".data"}, 32'(w.data), 32'(exp.data));
      check({name, ".perr"}, 32'(w.perr), 32'(exp.perr));
      check({name, ".ferr"}, 32'(w.ferr), 32'(exp.ferr));
      check({name, ".ovr"},  32'(w.ovr),  32'(exp.ovr));
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, ".rx_data"}, 32'(rx_data), 0);
    check({name, ".rx_valid"}, 32'(rx_valid), 0);
    check({name, ".parity_err"}, 32'(parity_err), 0);
    check({name, ".frame_err"}, 32'(frame_err), 0);
    check({name, ".overrun"}, 32'(overrun), 0);
    check({name, ".busy"}, 32'(busy), 0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h7E, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    hold_bits(1);
    check("post_reset.busy", 32'(busy), 0);

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].d, vecs[i].pbit, vecs[i].stop);
      rx = 1'b1;
      repeat (16) @(negedge clk);
      expect_word($sformatf("vec%0d", i), mk(vecs[i].d, vecs[i].exp_perr, vecs[i].exp_ferr, 1'b0));
      check($sformatf("vec%0d.busy", i), 32'(busy), 0);
    end
    check("valid_one_clk_per_frame", 32'(valid_cycles), 7);

    // Randomized frames against the model
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      logic pbit, stop;
      d    = 8'($urandom_range(0, 255));
      pbit = ($urandom_range(0, 2) == 0) ? !good_par(d) : good_par(d);
      stop = ($urandom_range(0, 5) != 0);
      send_frame(d, pbit, stop);
      rx = 1'b1;
      repeat (16 + $urandom_range(0, 40)) @(negedge clk);
      expect_word($sformatf("rand%0d", i), model(d, pbit, stop));
    end

    // Break: stop bit 0, line held low 40 bit-times, then clean frame
    send_frame(8'h00, good_par(8'h00), 1'b0);
    hold_bits(40);
    expect_word("break_first", mk(8'h00, 1'b0, 1'b1, 1'b0));
    check("break_no_extra", 32'(got_q.size()), 0);
    check("break_busy", 32'(busy), 0);
    rx = 1'b1;
    hold_bits(2);
    check("break_still_none", 32'(got_q.size()), 0);
    send_frame(8'h5A, good_par(8'h5A), 1'b1);
    repeat (16) @(negedge clk);
    expect_word("after_break", mk(8'h5A, 1'b0, 1'b0, 1'b0));

    // Glitch: low for 5 ticks
    @(negedge clk);
    rx = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_busy_set", 32'(busy), 1);
    repeat (5 * TICK_DIV - 12) @(negedge clk);
    rx = 1'b1;
    hold_bits(1);
    check("glitch_busy_clear", 32'(busy), 0);
    check("glitch_no_word", 32'(got_q.size()), 0);
    send_frame(8'h81, good_par(8'h81), 1'b1);
    repeat (16) @(negedge clk);
    expect_word("after_glitch", mk(8'h81, 1'b0, 1'b0, 1'b0));

    // Overrun
    @(posedge clk);
    #1 rx_ready = 1'b0;
    send_frame(8'h11, good_par(8'h11), 1'b1);
    repeat (16) @(negedge clk);
    check("ovr_first.valid", 32'(rx_valid), 1);
    check("ovr_first.data", 32'(rx_data), 32'h11);
    check("ovr_first.overrun", 32'(overrun), 0);
    send_frame(8'h22, good_par(8'h22), 1'b1);
    repeat (16) @(negedge clk);
    check("ovr_held.valid", 32'(rx_valid), 1);
    check("ovr_held.data", 32'(rx_data), 32'h11);
    check("ovr_held.overrun", 32'(overrun), 1);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("ovr_release.valid", 32'(rx_valid), 0);
    expect_word("ovr_release", mk(8'h11, 1'b0, 1'b0, 1'b1));
    send_frame(8'h33, good_par(8'h33), 1'b1);
    repeat (16) @(negedge clk);
    expect_word("after_ovr", mk(8'h33, 1'b0, 1'b0, 1'b0));

    // Reset mid-DATA of 0xF0, line left low
    @(negedge clk);
    rx = 1'b0;
    hold_bits(3);
    check("mid_frame.busy", 32'(busy), 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    hold_bits(4);
    check("mid_reset.no_word", 32'(got_q.size()), 0);
    check("mid_reset.busy_low", 32'(busy), 0);
    rx = 1'b1;
    hold_bits(2);
    send_frame(8'h96, good_par(8'h96), 1'b1);
    repeat (16) @(negedge clk);
    expect_word("after_reset", mk(8'h96, 1'b0, 1'b0, 1'b0));
    check("final_no_extra", 32'(got_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
